// File: rtl/cla_pkg.sv
// Shared constants and configuration check for the pipelined carry-lookahead adder.
package cla_pkg;

  localparam int GROUP_W    = 4;
  localparam int MAX_STAGES = 8;

  // True when WIDTH splits into STAGES slices made of whole lookahead groups.
  function automatic bit cfg_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= MAX_STAGES) && (width > 0) &&
           ((width % (GROUP_W * stages)) == 0);
  endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational N-bit adder built from 4-bit lookahead groups; group carries ripple
// from one group to the next.
module cla_slice
  import cla_pkg::*;
#(
  parameter int N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] s,
  output logic         c_out,
  output logic         c_msb_in
);

  localparam int NG = N / GROUP_W;

  logic [N-1:0] w_g;
  logic [N-1:0] w_p;
  logic [N:0]   w_c;

  assign w_g = a & b;
  assign w_p = a ^ b;

  // NOTE: blocking assignments here, so each loop step sees the value just computed.
  always_comb begin
    logic w_acc;
    logic w_pp;
    logic w_gcin;
    logic w_ci;
    w_acc  = 1'b0;
    w_pp   = 1'b1;
    w_ci   = 1'b0;
    w_gcin = c_in;
    w_c    = '0;
    w_c[0] = c_in;
    for (int j = 0; j < NG; j++) begin
      // Each carry inside a group is a flat sum of products of g/p and the group carry-in.
      for (int i = 0; i < GROUP_W; i++) begin
        w_acc = 1'b0;
        w_pp  = 1'b1;
        for (int m = i; m >= 0; m--) begin
          w_acc = w_acc | (w_pp & w_g[j*GROUP_W+m]);
          w_pp  = w_pp & w_p[j*GROUP_W+m];
        end
        w_ci = w_acc | (w_pp & w_gcin);
        w_c[j*GROUP_W+i+1] = w_ci;
      end
      w_gcin = w_ci;
    end
  end

  assign s        = w_p ^ w_c[N-1:0];
  assign c_out    = w_c[N];
  assign c_msb_in = w_c[N-1];

endmodule

// File: rtl/cla_pipe.sv
// Pipelined add/subtract: one slice per stage, slice carries and pending operand
// slices registered between stages, valid/ready handshake with global stall.
module cla_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);

  localparam int SW = WIDTH / STAGES;

  if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
    $error("cla_pipe: WIDTH must be a multiple of 4*STAGES, STAGES in 1..8");
  end

  logic              w_adv;
  logic [WIDTH-1:0]  w_b_eff;
  logic              w_cin_eff;
  logic [STAGES-1:0] r_valid;

  assign w_adv     = out_ready | ~out_valid;
  assign in_ready  = w_adv;
  assign w_b_eff   = sub ? ~b : b;
  assign w_cin_eff = sub | c_in;

  // NOTE: non-blocking assignments for all clocked state, so every stage samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else if (w_adv) begin
      r_valid <= STAGES'({r_valid, in_valid});
    end
  end

  assign out_valid = r_valid[STAGES-1];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int SUM_W = (k + 1) * SW;
    localparam int REM_W = WIDTH - SUM_W;

    logic [REM_W+SW-1:0] w_a_in;
    logic [REM_W+SW-1:0] w_b_in;
    logic [SUM_W-1:0]    w_sum_next;
    logic [SW-1:0]       w_s;
    logic                w_cin;
    logic                w_cout;
    logic                w_cmsb;
    logic [SUM_W-1:0]    r_sum;
    logic                r_carry;

    if (k == 0) begin : g_src
      assign w_a_in     = a;
      assign w_b_in     = w_b_eff;
      assign w_cin      = w_cin_eff;
      assign w_sum_next = w_s;
    end else begin : g_src
      assign w_a_in     = g_stage[k-1].g_ops.r_a;
      assign w_b_in     = g_stage[k-1].g_ops.r_b;
      assign w_cin      = g_stage[k-1].r_carry;
      assign w_sum_next = {w_s, g_stage[k-1].r_sum};
    end

    cla_slice #(.N(SW)) u_slice (
      .a        (w_a_in[SW-1:0]),
      .b        (w_b_in[SW-1:0]),
      .c_in     (w_cin),
      .s        (w_s),
      .c_out    (w_cout),
      .c_msb_in (w_cmsb)
    );

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_sum   <= '0;
        r_carry <= 1'b0;
      end else if (w_adv) begin
        r_sum   <= w_sum_next;
        r_carry <= w_cout;
      end
    end

    if (REM_W > 0) begin : g_ops
      logic [REM_W-1:0] r_a;
      logic [REM_W-1:0] r_b;
      // NOTE: pending operand slices carry no reset; r_valid alone says whether they mean anything.
      always_ff @(posedge clk) begin
        if (w_adv) begin
          r_a <= w_a_in[REM_W+SW-1:SW];
          r_b <= w_b_in[REM_W+SW-1:SW];
        end
      end
    end

    if (k == STAGES - 1) begin : g_last
      logic r_ovf;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_ovf <= 1'b0;
        end else if (w_adv) begin
          r_ovf <= w_cmsb ^ w_cout;
        end
      end
    end else begin : g_mid
      logic w_unused_cmsb;
      assign w_unused_cmsb = w_cmsb;
    end
  end

  assign sum   = g_stage[STAGES-1].r_sum;
  assign c_out = g_stage[STAGES-1].r_carry;
  assign ovf   = g_stage[STAGES-1].g_last.r_ovf;
  // Gated by valid so zero reads 0 in reset and between results.
  assign zero  = out_valid & ~|sum;

endmodule

// File: tb/tb_cla_pipe.sv
// Directed bench for cla_pipe (WIDTH=32, STAGES=2): streamed vector table plus
// back-pressure and mid-flight reset sequences.
module tb_cla_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        sub;
  logic        c_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        c_out;
  logic        ovf;
  logic        zero;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        c_in;
    logic [31:0] sum;
    logic        c_out;
    logic        ovf;
    logic        zero;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs[NV];

  cla_pipe #(.WIDTH(32), .STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] xa, input logic [31:0] xb,
                       input logic xsub, input logic xcin);
    a        = xa;
    b        = xb;
    sub      = xsub;
    c_in     = xcin;
    in_valid = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{32'h00000005, 32'h00000007, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{32'h00000007, 32'h00000007, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{32'h0000000A, 32'h00000003, 1'b1, 1'b1, 32'h00000007, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{32'h80000000, 32'h00000001, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 32'hACF13568, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
    vecs[9] = '{32'h00000001, 32'h00000001, 1'b0, 1'b1, 32'h00000003, 1'b0, 1'b0, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    sub       = 1'b0;
    c_in      = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst.out_valid", out_valid, 0);
    check("rst.in_ready",  in_ready,  1);
    check("rst.sum",       sum,       0);
    check("rst.c_out",     c_out,     0);
    check("rst.ovf",       ovf,       0);
    check("rst.zero",      zero,      0);

    // Table streamed one per cycle; the first is offered as reset drops.
    @(negedge clk);
    rst = 1'b0;
    for (int e = 0; e <= NV + 1; e++) begin
      if (e < NV) drive(vecs[e].a, vecs[e].b, vecs[e].sub, vecs[e].c_in);
      else in_valid = 1'b0;
      @(posedge clk);
      #1;
      if (e == 0 || e == NV + 1) begin
        check($sformatf("tab.e%0d.out_valid", e), out_valid, 0);
      end else begin
        check($sformatf("v%0d.out_valid", e - 1), out_valid, 1);
        check($sformatf("v%0d.sum",   e - 1), sum,   vecs[e-1].sum);
        check($sformatf("v%0d.c_out", e - 1), c_out, vecs[e-1].c_out);
        check($sformatf("v%0d.ovf",   e - 1), ovf,   vecs[e-1].ovf);
        check($sformatf("v%0d.zero",  e - 1), zero,  vecs[e-1].zero);
      end
      @(negedge clk);
    end

    // Back-pressure: 1+1 .. 4+4 with a three-cycle stall while the pipe is full
    drive(32'd1, 32'd1, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("bp.first.out_valid", out_valid, 0);
    @(negedge clk);
    drive(32'd2, 32'd2, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("bp.r1.out_valid", out_valid, 1);
    check("bp.r1.sum", sum, 32'd2);
    @(negedge clk);
    drive(32'd3, 32'd3, 1'b0, 1'b0);
    out_ready = 1'b0;
    #1;
    check("bp.stall.in_ready", in_ready, 0);
    for (int s = 0; s < 3; s++) begin
      @(posedge clk); #1;
      check($sformatf("bp.stall%0d.out_valid", s), out_valid, 1);
      check($sformatf("bp.stall%0d.sum", s), sum, 32'd2);
      check($sformatf("bp.stall%0d.c_out", s), c_out, 0);
      check($sformatf("bp.stall%0d.in_ready", s), in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    check("bp.resume.in_ready", in_ready, 1);
    @(posedge clk); #1;
    check("bp.r2.sum", sum, 32'd4);
    check("bp.r2.out_valid", out_valid, 1);
    @(negedge clk);
    drive(32'd4, 32'd4, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("bp.r3.sum", sum, 32'd6);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("bp.r4.sum", sum, 32'd8);
    check("bp.r4.out_valid", out_valid, 1);
    @(posedge clk); #1;
    check("bp.drain.out_valid", out_valid, 0);

    // Reset with two transactions in flight
    @(negedge clk);
    drive(32'd100, 32'd1, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(32'd200, 32'd2, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("mr.pre.out_valid", out_valid, 1);
    check("mr.pre.sum", sum, 32'd101);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check("mr.async.out_valid", out_valid, 0);
    check("mr.async.sum", sum, 0);
    check("mr.async.in_ready", in_ready, 1);
    check("mr.async.zero", zero, 0);
    @(posedge clk); #1;
    check("mr.held.out_valid", out_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(32'd40, 32'd2, 1'b0, 1'b0);
    #1;
    check("mr.post.in_ready", in_ready, 1);
    @(posedge clk); #1;
    check("mr.fresh1.out_valid", out_valid, 0);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("mr.fresh2.out_valid", out_valid, 1);
    check("mr.fresh2.sum", sum, 32'd42);
    @(posedge clk); #1;
    check("mr.after.out_valid", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cla_pipe.md
CLA_PIPE -- requirements
Module: cla_pipe

Interface
REQ-001 The parameter list SHALL be `WIDTH`, default 32, operand/result width; must be a multiple of 4*STAGES.
REQ-002 The parameter list SHALL include `STAGES`, default 2, pipeline depth; range 1..8.
REQ-003 Port `clk`, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port `rst`, input, 1 bit: reset, asynchronous and active-high.
REQ-005 Port `in_valid`, input, 1 bit: the operand set on `a`/`b`/`sub`/`c_in` is offered.
REQ-006 Port `in_ready`, output, 1 bit: the block accepts the offered set this cycle.
REQ-007 Port `a`, input, WIDTH bits: first operand.
REQ-008 Port `b`, input, WIDTH bits: second operand.
REQ-009 Port `sub`, input, 1 bit: 1 = subtract (a - b), 0 = add.
REQ-010 Port `c_in`, input, 1 bit: carry-in, used only when sub=0.
REQ-011 Port `out_valid`, output, 1 bit: a result is presented.
REQ-012 Port `out_ready`, input, 1 bit: the consumer takes the presented result.
REQ-013 Port `sum`, output, WIDTH bits: result.
REQ-014 Port `c_out`, output, 1 bit: carry out of bit WIDTH-1; for subtract, 1 = no borrow.
REQ-015 Port `ovf`, output, 1 bit: signed two's-complement overflow.
REQ-016 Port `zero`, output, 1 bit: sum == 0.

Function
REQ-017 Subtract SHALL be computed as a + ~b + 1; c_in SHALL be ignored when sub=1.
REQ-018 The operand SHALL be split into STAGES slices of WIDTH/STAGES bits; stage k SHALL add slice k using 4-bit lookahead groups and pass its slice carry-out to stage k+1 through a pipeline register.
REQ-019 Operand slices not yet consumed SHALL be delayed in pipeline registers, and completed sum slices SHALL be carried alongside, so each transaction stays aligned.
REQ-020 A handshake SHALL occur on a cycle with in_valid & in_ready; a result SHALL leave on a cycle with out_valid & out_ready.
REQ-021 Global advance: adv = out_ready | ~out_valid. All stage registers and valid bits SHALL shift only when adv=1, and SHALL hold otherwise.
REQ-022 in_ready SHALL equal adv, combinationally; no combinational path SHALL exist from in_valid to in_ready.
REQ-023 Latency SHALL be exactly STAGES cycles from handshake to out_valid when there is no stall; throughput SHALL be one result per cycle.
REQ-024 Bubbles SHALL propagate and SHALL NOT be squeezed out; a stage valid bit SHALL take its upstream valid (in_valid for stage 0) when adv=1.
REQ-025 While out_valid=1 and out_ready=0, sum, c_out, ovf and zero SHALL remain stable.
REQ-026 ovf SHALL equal the carry into the MSB XOR the carry out of the MSB.
REQ-027 zero SHALL be computed from the final registered sum.
REQ-028 Transactions SHALL emerge in acceptance order, with none lost or duplicated.

Reset
REQ-029 rst=1 SHALL clear all stage valid bits immediately, with no clock edge required, so out_valid=0.
REQ-030 During reset, sum, c_out, ovf and zero SHALL read 0.
REQ-031 In-flight transactions SHALL be discarded on reset.
REQ-032 in_ready SHALL read 1 during and after reset.
REQ-033 The first handshake SHALL be possible on the first rising edge after rst deasserts.

Structure
REQ-034 Shared package `cla_pkg` SHALL hold GROUP_W=4 and the MAX_STAGES=8 limit, plus an elaboration check for WIDTH % (GROUP_W*STAGES) == 0.
REQ-035 A combinational sub-module `cla_slice` SHALL implement an N-bit group-lookahead adder (inputs a, b, c_in; outputs s, c_out, c_msb_in), instantiated once per stage.
REQ-036 Pipeline registers and handshake logic SHALL live in cla_pipe only.

Verification (WIDTH=32, STAGES=2)
REQ-037 Add 0x7FFFFFFF + 0x00000001, sub=0, c_in=0 -> after 2 cycles sum=0x80000000, c_out=0, ovf=1, zero=0.
REQ-038 Sub 5 - 7, then 7 - 7 on consecutive cycles -> sum=0xFFFFFFFE with c_out=0, ovf=0; then sum=0 with c_out=1, zero=1.
REQ-039 Cross-slice carry: 0x0000FFFF + 0x00000001 -> sum=0x00010000; and 0xFFFFFFFF + 0 with c_in=1 -> sum=0, c_out=1, zero=1.
REQ-040 Back-pressure: stream 4 adds (i + i) for i=1..4, hold out_ready=0 for 3 cycles mid-stream -> results 2, 4, 6, 8 in order, outputs stable while stalled, in_ready=0 while stalled and full.
REQ-041 Reset mid-operation: accept 2 transactions, assert rst between clock edges -> out_valid drops at once, neither result ever appears, in_ready=1, and a fresh op completes normally 2 cycles after its handshake.
